// File: rtl/interval_meter_16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interval_meter_16_pkg
// Description : Shared definitions for the interval meter: FSM state
//               encoding and the default counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package interval_meter_16_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/interval_meter_16_prescale_tick.sv
`default_nettype none
// ============================================================================
// Module      : interval_meter_16_prescale_tick
// Description : Modulo-PRESCALE tick generator with synchronous clear.
//               Emits a one-cycle tick every PRESCALE enabled cycles; with
//               PRESCALE=1 the tick is constantly high while enabled.
// Ports       : clk      - system clock
//               reset    - synchronous active-high reset
//               clear_i  - restart the count; the first tick then lands
//                          PRESCALE enabled cycles later
//               enable_i - count this cycle
//               tick_o   - one-cycle tick
// Revision    : 1.0 - initial release
// ============================================================================
module interval_meter_16_prescale_tick #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    // A 1-bit counter is kept even for PRESCALE=1; it then stays at zero,
    // which equals LAST, so the tick simply follows enable.
    localparam int             CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/interval_meter_16.sv
`default_nettype none
// ============================================================================
// Module      : interval_meter_16
// Description : Measures the interval between a start and a stop pulse in
//               prescaled ticks, with an optional timeout limit.
// Ports       : clk       - system clock (rising edge)
//               reset     - synchronous active-high reset
//               start     - begin measurement (ignored while running)
//               stop      - end measurement (ignored while idle)
//               max_count - timeout limit in ticks, 0 = all-ones
//               count     - last measured interval, held until next result
//               valid     - one-cycle pulse when count/overflow update
//               overflow  - last result was ended by timeout
//               busy      - measurement in progress
// Revision    : 1.0 - initial release
// ============================================================================
module interval_meter_16
    import interval_meter_16_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] max_count,
    output logic [WIDTH-1:0] count,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic             w_tick;
    logic             w_clear;
    logic             w_run;
    logic [WIDTH-1:0] w_limit;
    logic [WIDTH:0]   w_next;

    assign w_run   = (state_q == ST_RUN);
    assign w_limit = (max_count == '0) ? '1 : max_count;
    // One extra bit so a lowered limit below the running count still
    // compares correctly and nothing can wrap.
    assign w_next  = {1'b0, cnt_q} + 1'b1;

    interval_meter_16_prescale_tick #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (w_clear),
        .enable_i (w_run),
        .tick_o   (w_tick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        w_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    w_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    // The tick on the stop edge itself is included.
                    count_d = w_tick ? w_next[WIDTH-1:0] : cnt_q;
                    ovf_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (w_tick && (w_next >= {1'b0, w_limit})) begin
                    count_d = w_limit;
                    ovf_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (w_tick) begin
                    cnt_d = w_next[WIDTH-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign count    = count_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;
    assign busy     = w_run;

endmodule
`default_nettype wire

// File: tb/tb_interval_meter_16.sv
`default_nettype none
// ============================================================================
// Module      : tb_interval_meter_16
// Description : Self-checking bench for interval_meter_16. Two instances
//               (PRESCALE=1 and PRESCALE=4) share the stimulus; a timeline
//               model derives every result from start/stop edge numbers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interval_meter_16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [15:0] max_count;

    logic [15:0] c1, c4;
    logic        v1, v4, o1, o4, b1, b4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    interval_meter_16 #(.WIDTH(16), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .max_count(max_count), .count(c1), .valid(v1),
        .overflow(o1), .busy(b1)
    );

    interval_meter_16 #(.WIDTH(16), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .max_count(max_count), .count(c4), .valid(v4),
        .overflow(o4), .busy(b4)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // ---------------- timeline model ----------------
    // A run started on edge s and stopped on edge e yields (e-s)/P ticks;
    // a timeout happens on the first tick edge where the tick total reaches
    // the limit.
    int cyc = 0;
    bit seen_reset = 1'b0;
    int m_run[2] = '{0, 0};
    int m_st [2] = '{0, 0};
    int m_cnt[2] = '{0, 0};
    int m_ov [2] = '{0, 0};
    int m_val[2] = '{0, 0};

    always @(posedge clk) begin
        int k, p, lim;
        cyc++;
        lim = (max_count == 16'd0) ? 65535 : int'(max_count);
        for (int j = 0; j < 2; j++) begin
            p = (j == 0) ? 1 : 4;
            m_val[j] = 0;
            if (reset) begin
                m_run[j] = 0; m_cnt[j] = 0; m_ov[j] = 0;
            end else if (m_run[j] != 0) begin
                k = cyc - m_st[j];
                if (stop) begin
                    m_cnt[j] = k / p; m_ov[j] = 0; m_val[j] = 1; m_run[j] = 0;
                end else if ((k % p == 0) && (k / p >= lim)) begin
                    m_cnt[j] = lim; m_ov[j] = 1; m_val[j] = 1; m_run[j] = 0;
                end
            end else if (start) begin
                m_run[j] = 1; m_st[j] = cyc;
            end
        end
        if (reset) seen_reset = 1'b1;
        #1;
        if (seen_reset) begin
            chk("model count P1",    int'(c1), m_cnt[0]);
            chk("model valid P1",    int'(v1), m_val[0]);
            chk("model overflow P1", int'(o1), m_ov[0]);
            chk("model busy P1",     int'(b1), m_run[0]);
            chk("model count P4",    int'(c4), m_cnt[1]);
            chk("model valid P4",    int'(v4), m_val[1]);
            chk("model overflow P4", int'(o4), m_ov[1]);
            chk("model busy P4",     int'(b4), m_run[1]);
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change on falling edges; after pulse_start the bench sits just
    // after the edge (t) that sampled start.
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; max_count = 16'd0;
        wait_neg(3);
        chk("reset count",    int'(c1), 0);
        chk("reset valid",    int'(v1), 0);
        chk("reset overflow", int'(o1), 0);
        chk("reset busy",     int'(b1), 0);
        reset = 1'b0;

        // Basic measurement, stop at t+25.
        pulse_start();
        wait_neg(24); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("k25 count",    int'(c1), 25);
        chk("k25 valid",    int'(v1), 1);
        chk("k25 overflow", int'(o1), 0);
        chk("k25 busy",     int'(b1), 0);
        chk("k25 count P4", int'(c4), 6);
        @(negedge clk);
        chk("k25 valid one cycle", int'(v1), 0);

        // Timeout at limit 10.
        max_count = 16'd10;
        pulse_start();
        wait_neg(9);
        chk("to busy before", int'(b1), 1);
        chk("to valid before", int'(v1), 0);
        @(negedge clk);
        chk("to count",    int'(c1), 10);
        chk("to overflow", int'(o1), 1);
        chk("to valid",    int'(v1), 1);
        chk("to busy",     int'(b1), 0);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("late stop valid", int'(v1), 0);
        chk("late stop count", int'(c1), 10);
        chk("late stop ovf",   int'(o1), 1);
        max_count = 16'd0;
        wait_neg(2);

        // Prescale 4: stop at t+17 then t+3.
        pulse_start();
        wait_neg(16); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("p4 k17 count", int'(c4), 4);
        chk("p4 k17 valid", int'(v4), 1);
        pulse_start();
        wait_neg(2); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("p4 k3 count", int'(c4), 0);
        chk("p4 k3 valid", int'(v4), 1);
        chk("p4 k3 ovf",   int'(o4), 0);

        // start and stop together in IDLE: start wins.
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        chk("start+stop busy",  int'(b1), 1);
        chk("start+stop valid", int'(v1), 0);
        wait_neg(3); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("start+stop result", int'(c1), 4);

        // stop alone in IDLE does nothing.
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("idle stop valid", int'(v1), 0);
        chk("idle stop busy",  int'(b1), 0);

        // Second start at t+5 is ignored; stop at t+20.
        pulse_start();
        wait_neg(4); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_neg(14); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("restart ignored count", int'(c1), 20);

        // Stop on the limit edge: stop wins.
        max_count = 16'd10;
        pulse_start();
        wait_neg(9); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("stop@limit count", int'(c1), 10);
        chk("stop@limit ovf",   int'(o1), 0);
        chk("stop@limit valid", int'(v1), 1);
        max_count = 16'd0;
        wait_neg(2);

        // Back-to-back: new start on the valid cycle.
        pulse_start();
        wait_neg(6); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("b2b first count", int'(c1), 7);
        chk("b2b first valid", int'(v1), 1);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("b2b accepted busy", int'(b1), 1);
        chk("b2b held count",    int'(c1), 7);
        chk("b2b no valid",      int'(v1), 0);
        wait_neg(11); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("b2b second count", int'(c1), 12);
        chk("b2b second valid", int'(v1), 1);

        // Reset mid-run at t+5.
        pulse_start();
        wait_neg(4); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("rst run busy",  int'(b1), 0);
        chk("rst run valid", int'(v1), 0);
        chk("rst run count", int'(c1), 0);
        chk("rst run ovf",   int'(o1), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst run no valid", int'(v1), 0);
        end

        wait_neg(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
